// File: rtl/stopwatch_pkg.sv
// Shared time type, run-state encoding and carry/borrow counting helpers
// for the stopwatch/lap-timer core.
package stopwatch_pkg;

  localparam int TICKS_PER_SEC = 100;
  localparam int SECS_PER_MIN  = 60;

  typedef struct packed {
    logic [6:0] ms_10;
    logic [5:0] secs;
    logic [5:0] mins;
  } sw_time_t;

  typedef struct packed {
    sw_time_t t;
    logic     wrap;
  } sw_step_t;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

  // wrap flags that t was already at the top of the range (max_m1:59:99).
  function automatic sw_step_t sw_inc(input sw_time_t t, input logic [5:0] max_m1);
    sw_step_t r;
    r.t    = t;
    r.wrap = 1'b0;
    if (t.ms_10 != 7'(TICKS_PER_SEC - 1)) begin
      r.t.ms_10 = t.ms_10 + 7'd1;
    end else begin
      r.t.ms_10 = '0;
      if (t.secs != 6'(SECS_PER_MIN - 1)) begin
        r.t.secs = t.secs + 6'd1;
      end else begin
        r.t.secs = '0;
        if (t.mins != max_m1) begin
          r.t.mins = t.mins + 6'd1;
        end else begin
          r.t.mins = '0;
          r.wrap   = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // wrap flags that t was already 0:00:00.
  function automatic sw_step_t sw_dec(input sw_time_t t, input logic [5:0] max_m1);
    sw_step_t r;
    r.t    = t;
    r.wrap = 1'b0;
    if (t.ms_10 != 7'd0) begin
      r.t.ms_10 = t.ms_10 - 7'd1;
    end else begin
      r.t.ms_10 = 7'(TICKS_PER_SEC - 1);
      if (t.secs != 6'd0) begin
        r.t.secs = t.secs - 6'd1;
      end else begin
        r.t.secs = 6'(SECS_PER_MIN - 1);
        if (t.mins != 6'd0) begin
          r.t.mins = t.mins - 6'd1;
        end else begin
          r.t.mins = max_m1;
          r.wrap   = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_lap_timer_if.sv
// Button/mode inputs and display/status outputs of the stopwatch core.
interface stopwatch_lap_timer_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic             start_stop;
  logic             lap;
  logic             clear;
  logic             count_down;
  logic [5:0]       preset_mins;
  logic [6:0]       ms_10;
  logic [5:0]       secs;
  logic [5:0]       mins;
  logic             running;
  logic             done;
  logic             showing_lap;
  logic [CNT_W-1:0] lap_count;

  modport master (
    output start_stop, lap, clear, count_down, preset_mins,
    input  ms_10, secs, mins, running, done, showing_lap, lap_count
  );

  modport slave (
    input  start_stop, lap, clear, count_down, preset_mins,
    output ms_10, secs, mins, running, done, showing_lap, lap_count
  );
endinterface

// File: rtl/stopwatch_tick_gen.sv
// Hundredth-of-a-second prescaler; holds its count while disabled so a
// resumed run finishes the partial period.
module stopwatch_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int DIV = CLK_HZ / 100;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == CW'(DIV - 1));
  assign o_tick = i_en & w_term;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/stopwatch_lap_timer.sv
// Up/down stopwatch with circular lap buffer and lap recall; display and
// status outputs are registered from next-state values.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int MAX_MINS  = 60,
  parameter int LAP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stopwatch_lap_timer_if.slave sw
);
  localparam int         CNT_W  = $clog2(LAP_DEPTH + 1);
  localparam int         PTR_W  = $clog2(LAP_DEPTH);
  localparam logic [5:0] MAX_M1 = 6'(MAX_MINS - 1);

  // {clear, start_stop, lap}: _p0 is the synchronised sample, _p1 the one before
  logic [2:0]       r_btn_p0, r_btn_p1;
  logic             w_ev_clr, w_ev_ss, w_ev_lap;

  run_state_t       r_state, w_state_nx;
  sw_time_t         r_time, w_time_nx;
  logic             r_down, w_down_nx;
  logic [CNT_W-1:0] r_lap_cnt, w_lap_cnt_nx;
  logic [CNT_W-1:0] r_view, w_view_nx;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_lap_we;
  sw_time_t         r_laps [LAP_DEPTH];
  sw_time_t         r_disp, w_disp_nx;
  logic             r_show, r_running, r_done;
  logic             w_tick;
  logic [5:0]       w_preset;
  sw_step_t         w_inc, w_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_p0 <= '0;
      r_btn_p1 <= '0;
    end else begin
      r_btn_p0 <= {sw.clear, sw.start_stop, sw.lap};
      r_btn_p1 <= r_btn_p0;
    end
  end

  // Only the highest-priority event of a cycle acts
  assign w_ev_clr = r_btn_p0[2] & ~r_btn_p1[2];
  assign w_ev_ss  = r_btn_p0[1] & ~r_btn_p1[1] & ~w_ev_clr;
  assign w_ev_lap = r_btn_p0[0] & ~r_btn_p1[0] & ~w_ev_clr & ~w_ev_ss;

  stopwatch_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (r_state == ST_RUN),
    .i_clr   (w_ev_clr),
    .o_tick  (w_tick)
  );

  assign w_preset = (sw.preset_mins > MAX_M1) ? MAX_M1 : sw.preset_mins;
  assign w_inc    = sw_inc(r_time, MAX_M1);
  assign w_dec    = sw_dec(r_time, MAX_M1);

  always_comb begin
    w_state_nx   = r_state;
    w_time_nx    = r_time;
    w_down_nx    = r_down;
    w_lap_cnt_nx = r_lap_cnt;
    w_view_nx    = r_view;
    w_lap_we     = 1'b0;
    if (w_ev_clr) begin
      w_state_nx   = ST_STOP;
      w_down_nx    = sw.count_down;
      w_lap_cnt_nx = '0;
      w_view_nx    = '0;
      w_time_nx    = '0;
      if (sw.count_down) w_time_nx.mins = w_preset;
    end else begin
      if (w_ev_ss) begin
        w_view_nx = '0;
        case (r_state)
          ST_STOP: w_state_nx = ST_RUN;
          ST_RUN:  w_state_nx = ST_STOP;
          default: w_state_nx = r_state;
        endcase
      end else if (w_ev_lap) begin
        if (r_state == ST_RUN) begin
          w_lap_we = 1'b1;
          if (r_lap_cnt != CNT_W'(LAP_DEPTH)) w_lap_cnt_nx = r_lap_cnt + CNT_W'(1);
        end else if (r_lap_cnt != '0) begin
          w_view_nx = (r_view == r_lap_cnt) ? '0 : r_view + CNT_W'(1);
        end
      end
      // The end of the range stops the count instead of wrapping
      if (w_tick) begin
        if (!r_down) begin
          if (w_inc.wrap) w_state_nx = ST_DONE;
          else            w_time_nx  = w_inc.t;
        end else begin
          if (w_dec.wrap) begin
            w_state_nx = ST_DONE;
          end else begin
            w_time_nx = w_dec.t;
            if (w_dec.t == '0) w_state_nx = ST_DONE;
          end
        end
      end
    end
  end

  // View k (1..lap_count) is the k-th newest entry, just behind the write pointer
  assign w_rd_idx  = r_wr_ptr - PTR_W'(w_view_nx);
  assign w_disp_nx = (w_view_nx != '0) ? r_laps[w_rd_idx] : w_time_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_STOP;
      r_time    <= '0;
      r_down    <= 1'b0;
      r_lap_cnt <= '0;
      r_view    <= '0;
      r_wr_ptr  <= '0;
      r_disp    <= '0;
      r_show    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_time    <= w_time_nx;
      r_down    <= w_down_nx;
      r_lap_cnt <= w_lap_cnt_nx;
      r_view    <= w_view_nx;
      r_disp    <= w_disp_nx;
      r_show    <= (w_view_nx != '0);
      r_running <= (w_state_nx == ST_RUN);
      r_done    <= (w_state_nx == ST_DONE);
      if (w_ev_clr)      r_wr_ptr <= '0;
      else if (w_lap_we) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_lap_we) r_laps[r_wr_ptr] <= r_time;
  end

  assign sw.ms_10       = r_disp.ms_10;
  assign sw.secs        = r_disp.secs;
  assign sw.mins        = r_disp.mins;
  assign sw.running     = r_running;
  assign sw.done        = r_done;
  assign sw.showing_lap = r_show;
  assign sw.lap_count   = r_lap_cnt;
endmodule

// File: doc/stopwatch_lap_timer.md
# stopwatch_lap_timer

Parametrised stopwatch/timer core that supersedes the fixed start/stop/reset stopwatch datapath. It counts hundredths, seconds and minutes up, or down from a preset. It captures lap times into a small circular buffer and lets the user recall them onto the display when stopped. It sits between the board's inverted KEY/SW inputs and the existing seven-segment display driver, which consumes `ms_10`/`secs`/`mins` unchanged.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; must be a multiple of 100.
- `MAX_MINS`, 60, minute modulus; legal range 1..64.
- `LAP_DEPTH`, 4, number of lap entries; power of two, 2..16.
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: level, active-high button (already inverted); acts on rising edge.
- `lap` in 1: level, active-high button; acts on rising edge.
- `clear` in 1: level, active-high button; acts on rising edge.
- `count_down` in 1: mode select, 0 = up, 1 = down; sampled only when `clear` is accepted.
- `preset_mins` in 6: countdown start value in minutes, loaded on clear; values ≥ MAX_MINS clamp to MAX_MINS-1.
- `ms_10` out 7: displayed hundredths, 0..99.
- `secs` out 6: displayed seconds, 0..59.
- `mins` out 6: displayed minutes, 0..MAX_MINS-1.
- `running` out 1: counter is advancing.
- `done` out 1: countdown reached zero, or count-up saturated; sticky until clear.
- `showing_lap` out 1: display shows a stored lap, not the live time.
- `lap_count` out $clog2(LAP_DEPTH+1): number of valid laps, saturating at LAP_DEPTH.

## Operation
- Edge detect: each button is registered once; the event pulse = current & ~previous, so there is 1 cycle of latency.
- Event priority in one cycle: clear > start_stop > lap.
- Clear:
  - Stops the counter and clears the prescaler, `done`, the lap buffer and the view index.
  - Latches `count_down`.
  - Live time loads 0:00:00 (up mode) or preset:00:00 (down mode).
- start_stop toggles `running`. It is ignored while `done`=1.
- Tick: the prescaler counts 0..CLK_HZ/100-1 only while running; the terminal count produces a one-cycle tick. The prescaler holds its value when stopped, so a resume continues the partial period.
- Up count on tick:
  - ms_10 99→0 carries into secs; secs 59→0 carries into mins.
  - At (MAX_MINS-1):59:99 the next tick does not wrap: the time holds, `running`←0, `done`←1.
- Down count on tick: borrows mirror the up count. On reaching 0:00:00 `running`←0 and `done`←1 in the same cycle. Starting from 0:00:00 in down mode sets `done` at the first tick.
- Lap while running:
  - Writes the live time to buffer[wr_ptr]; wr_ptr increments modulo LAP_DEPTH.
  - `lap_count` increments, saturating. When full, the oldest entry is overwritten.
  - Live view is kept.
- Lap while stopped: steps the view index through the stored laps, newest first, then back to live. With `lap_count`=0 it has no effect.
- Any start_stop event returns the view to live.
- A lap captured on a tick cycle stores the pre-tick value.

## Timing
- Reset values:
  - time 0:00:00, up mode.
  - `running`=0, `done`=0, `showing_lap`=0, `lap_count`=0.
  - Prescaler 0, buffer pointers 0.
- Outputs are registered.
- Button to state change: 2 cycles after the input rises (1 sync register + 1 state update).
- First tick after start: CLK_HZ/100 cycles after `running` rises, from a cleared prescaler.
- Reset asserted mid-count forces all reset values immediately, with no flush. Button registers also reset to 0, so a button held through reset release is seen as an edge.

## Structure
- Package `stopwatch_pkg` holds:
  - `TICKS_PER_SEC`=100 and `SECS_PER_MIN`=60.
  - A `sw_time_t` struct {ms_10[6:0], secs[5:0], mins[5:0]}.
  - Increment and decrement functions with carry/borrow flags.
- Sub-module `stopwatch_tick_gen`: prescaler with `CLK_HZ` parameter and enable, clear and tick signals.
- The lap buffer is an inferred register array in the top; no RAM macro.

## Test plan
- CLK_HZ=1000 (10 cycles/tick), up mode:
  - start → after 1000 ticks shows 0:10:00.
  - stop → the value holds for 500 cycles.
- Down mode, preset=1 → clear → start: 0:59:99 after 1 tick; after 6000 ticks 0:00:00 with `done`=1 and `running`=0; a further start is ignored.
- MAX_MINS=2, up from 1:59:98: 2 ticks → holds at 1:59:99 with `done`=1.
- LAP_DEPTH=4:
  - 5 laps while running → `lap_count`=4 and the first lap is lost.
  - Stop, press lap 5× → views laps 5, 4, 3, 2, then live (`showing_lap`=0).
- clear and start_stop rising in the same cycle → stopped and cleared, `running`=0.
- reset_n pulsed low mid-count, asynchronous to clk → all outputs zero within the same cycle; the count resumes only after a new start.
